// File: rtl/flex_fifo.sv
// Circular-buffer FIFO with write-to-read bypass, peek, flush and sticky error flags.
// Optional peak-occupancy tracking is enabled by defining FLEX_FIFO_STATS_EN.
module flex_fifo #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH_BITS   = 3,
    parameter int unsigned AFULL_SLACK  = 2,
    parameter int unsigned AEMPTY_LEVEL = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  wrtEn,
    input  logic                  rdEn,
    input  logic                  peek,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  valid,
    output logic [DEPTH_BITS:0]   count,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [DEPTH_BITS:0]   high_water
);

    localparam int unsigned Depth = 1 << DEPTH_BITS;
    localparam int unsigned CntW  = DEPTH_BITS + 1;
    localparam logic [CntW-1:0] DepthCnt   = CntW'(Depth);
    localparam logic [CntW-1:0] AfullCnt   = CntW'(Depth - AFULL_SLACK);
    localparam logic [CntW-1:0] AemptyCnt  = CntW'(AEMPTY_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic is_empty, is_full, bypass, wr_acc, rd_acc;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DepthCnt);
    // A simultaneous read/write on an empty queue passes straight through, storing nothing.
    assign bypass   = wrtEn & rdEn & is_empty;
    assign wr_acc   = wrtEn & (~is_full | rdEn) & ~bypass & ~flush;
    assign rd_acc   = rdEn & ~is_empty & ~flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (wrtEn & ~rdEn & is_full & ~flush);
        underflow_d = underflow_q | (rdEn & ~wrtEn & is_empty & ~flush);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) mem_q[wr_ptr_q] <= write_data;
    end

    always_comb begin
        read_data    = mem_q[rd_ptr_q];
        valid        = (rdEn | peek) & ~is_empty;
        if (wrtEn & is_empty & (rdEn | peek)) begin
            read_data = write_data;
            valid     = 1'b1;
        end
        count        = count_q;
        full         = is_full;
        almost_full  = (count_q >= AfullCnt);
        empty        = is_empty;
        almost_empty = (count_q <= AemptyCnt);
        if (reset) begin
            valid        = 1'b0;
            count        = '0;
            full         = 1'b0;
            almost_full  = 1'b0;
            empty        = 1'b1;
            almost_empty = 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef FLEX_FIFO_STATS_EN
    logic [CntW-1:0] high_water_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            high_water_q <= '0;
        end else if (count_d > high_water_q) begin
            high_water_q <= count_d;
        end
    end

    assign high_water = high_water_q;
`else
    assign high_water = '0;
`endif

endmodule

// File: tb/tb_flex_fifo.sv
// Directed self-checking bench for flex_fifo with DEPTH_BITS=2, AFULL_SLACK=1, AEMPTY_LEVEL=1.
module tb_flex_fifo;

    localparam int unsigned DW = 8;
    localparam int unsigned DB = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] write_data;
    logic          wrtEn, rdEn, peek, flush;
    logic [DW-1:0] read_data;
    logic          valid, full, almost_full, empty, almost_empty, overflow, underflow;
    logic [DB:0]   count, high_water;

    int checks = 0;
    int failures = 0;

    flex_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH_BITS  (DB),
        .AFULL_SLACK (1),
        .AEMPTY_LEVEL(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .write_data  (write_data),
        .wrtEn       (wrtEn),
        .rdEn        (rdEn),
        .peek        (peek),
        .flush       (flush),
        .read_data   (read_data),
        .valid       (valid),
        .count       (count),
        .full        (full),
        .almost_full (almost_full),
        .empty       (empty),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow),
        .high_water  (high_water)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Registered outputs are checked 2 time units after the edge; inputs change there too.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic check_flags(input string tag, input int c, input logic f, input logic af,
                               input logic e, input logic ae);
        chk({tag, "_count"}, 32'(count), 32'(c));
        chk({tag, "_full"}, 32'(full), 32'(f));
        chk({tag, "_afull"}, 32'(almost_full), 32'(af));
        chk({tag, "_empty"}, 32'(empty), 32'(e));
        chk({tag, "_aempty"}, 32'(almost_empty), 32'(ae));
    endtask

    task automatic push(input logic [DW-1:0] d);
        write_data = d; wrtEn = 1'b1; rdEn = 1'b0; peek = 1'b0;
        tick();
        wrtEn = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [DW-1:0] exp);
        rdEn = 1'b1; wrtEn = 1'b0; peek = 1'b0;
        #1;
        chk({tag, "_data"}, 32'(read_data), 32'(exp));
        chk({tag, "_valid"}, 32'(valid), 32'(1));
        tick();
        rdEn = 1'b0;
    endtask

    initial begin
        // Reset with bypass-capable inputs: outputs must be forced regardless.
        reset = 1'b1; wrtEn = 1'b1; rdEn = 1'b1; peek = 1'b0; flush = 1'b0; write_data = 8'h77;
        #1;
        chk("rst_comb_valid", 32'(valid), 32'(0));
        check_flags("rst_comb", 0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        reset = 1'b0; wrtEn = 1'b0; rdEn = 1'b0;
        tick();
        check_flags("post_rst", 0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("post_rst_ovf", 32'(overflow), 32'(0));
        chk("post_rst_unf", 32'(underflow), 32'(0));
        chk("post_rst_hw", 32'(high_water), 32'(0));

        // Fill to full, watching the thresholds.
        push(8'hA1); check_flags("fill1", 1, 1'b0, 1'b0, 1'b0, 1'b1);
        push(8'hA2); check_flags("fill2", 2, 1'b0, 1'b0, 1'b0, 1'b0);
        push(8'hA3); check_flags("fill3", 3, 1'b0, 1'b1, 1'b0, 1'b0);
        push(8'hA4); check_flags("fill4", 4, 1'b1, 1'b1, 1'b0, 1'b0);
        peek = 1'b1; #1;
        chk("peek_full_data", 32'(read_data), 32'h A1);
        chk("peek_full_valid", 32'(valid), 32'(1));
        tick(); peek = 1'b0;
        chk("peek_keeps_count", 32'(count), 32'(4));
        pop("rd1", 8'hA1);
        pop("rd2", 8'hA2);
        pop("rd3", 8'hA3);
        pop("rd4", 8'hA4);
        check_flags("drained", 0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        chk("idle_valid", 32'(valid), 32'(0));

        // Bypass on an empty queue stores nothing.
        write_data = 8'h55; wrtEn = 1'b1; rdEn = 1'b1; #1;
        chk("byp_data", 32'(read_data), 32'h55);
        chk("byp_valid", 32'(valid), 32'(1));
        tick(); wrtEn = 1'b0; rdEn = 1'b0;
        chk("byp_count", 32'(count), 32'(0));
        chk("byp_unf", 32'(underflow), 32'(0));

        // Peek-write on empty shows the data and stores it.
        write_data = 8'h66; wrtEn = 1'b1; peek = 1'b1; #1;
        chk("pkw_data", 32'(read_data), 32'h66);
        chk("pkw_valid", 32'(valid), 32'(1));
        tick(); wrtEn = 1'b0; #1;
        chk("pkw_count", 32'(count), 32'(1));
        chk("pkw_head", 32'(read_data), 32'h66);
        peek = 1'b0;
        push(8'h11); push(8'h22); push(8'h33);
        chk("full_again", 32'(full), 32'(1));

        // Read+write while full: head leaves, new data enters, no overflow.
        write_data = 8'h99; wrtEn = 1'b1; rdEn = 1'b1; #1;
        chk("rw_full_data", 32'(read_data), 32'h66);
        tick(); rdEn = 1'b0;
        chk("rw_full_count", 32'(count), 32'(4));
        chk("rw_full_ovf", 32'(overflow), 32'(0));
        write_data = 8'hEE;
        tick(); wrtEn = 1'b0;
        chk("ovf_set", 32'(overflow), 32'(1));
        chk("ovf_count", 32'(count), 32'(4));
        pop("rw1", 8'h11);
        pop("rw2", 8'h22);
        pop("rw3", 8'h33);
        pop("rw4", 8'h99);

        // Underflow is sticky.
        rdEn = 1'b1; #1;
        chk("unf_valid", 32'(valid), 32'(0));
        tick(); rdEn = 1'b0;
        chk("unf_set", 32'(underflow), 32'(1));
        tick();
        chk("unf_sticky", 32'(underflow), 32'(1));

        // Flush beats a same-cycle write and leaves sticky flags alone.
        push(8'h01); push(8'h02); push(8'h03);
        chk("pre_flush_count", 32'(count), 32'(3));
        flush = 1'b1; wrtEn = 1'b1; write_data = 8'h04;
        tick(); flush = 1'b0; wrtEn = 1'b0;
        check_flags("flush", 0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("flush_ovf", 32'(overflow), 32'(1));
        chk("flush_unf", 32'(underflow), 32'(1));
        push(8'h05);
        peek = 1'b1; #1;
        chk("post_flush_head", 32'(read_data), 32'h05);
        peek = 1'b0;
`ifdef FLEX_FIFO_STATS_EN
        chk("hw_peak4", 32'(high_water), 32'(4));
`else
        chk("hw_tied", 32'(high_water), 32'(0));
`endif

        // Reset forces outputs while a stored entry still exists.
        reset = 1'b1; peek = 1'b1; #1;
        chk("rst2_valid", 32'(valid), 32'(0));
        check_flags("rst2_comb", 0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); reset = 1'b0; peek = 1'b0;
        chk("rst2_ovf", 32'(overflow), 32'(0));
        chk("rst2_unf", 32'(underflow), 32'(0));
        chk("rst2_hw", 32'(high_water), 32'(0));
        check_flags("rst2", 0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Peak tracking: fill to 3, drain.
        push(8'hB1); push(8'hB2); push(8'hB3);
        pop("hw1", 8'hB1);
        pop("hw2", 8'hB2);
        pop("hw3", 8'hB3);
`ifdef FLEX_FIFO_STATS_EN
        chk("hw_peak3", 32'(high_water), 32'(3));
`else
        chk("hw_tied2", 32'(high_water), 32'(0));
`endif
        reset = 1'b1;
        tick(); reset = 1'b0;
        chk("hw_after_rst", 32'(high_water), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
